// File: rtl/seq_barrel_shifter.sv
// Multi-cycle LSR/LSL/ASR/ROR shifter, STEP bits per clock; SHIFT_CARRY_EN adds the carry output.
// Latency: done pulses 1+ceil(n/STEP) cycles after an accepted start (n=0 -> next cycle).
// Backpressure: start is ignored while busy; operands are captured only on an accepted start.
module seq_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] n,
  input  logic [WIDTH-1:0]   Rin,
  output logic [WIDTH-1:0]   Rx,
  output logic               busy,
  output logic               done
`ifdef SHIFT_CARRY_EN
  ,
  output logic               carry
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state, state_next;
  logic               accept;
  logic [1:0]         mode_q;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] step_amt;
  logic [WIDTH-1:0]   shift_res;

  // Final step may be shorter than STEP so the total equals n exactly.
  assign step_amt = (count < STEP_AMT) ? count : STEP_AMT;

  always_comb begin
    shift_res = Rx;
    case (mode_q)
      M_LSR:   shift_res = Rx >> step_amt;
      M_LSL:   shift_res = Rx << step_amt;
      M_ASR:   shift_res = $signed(Rx) >>> step_amt;
      M_ROR:   shift_res = (Rx >> step_amt) | (Rx << (WIDTH - int'(step_amt)));
      default: shift_res = Rx;
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (n != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (count == step_amt) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // busy/done come straight from flops, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_SHIFT);
      done  <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Rx     <= '0;
      count  <= '0;
      mode_q <= M_LSR;
    end else if (accept) begin
      Rx     <= Rin;
      count  <= n;
      mode_q <= mode;
    end else if (state == S_SHIFT) begin
      Rx     <= shift_res;
      count  <= count - step_amt;
    end
  end

`ifdef SHIFT_CARRY_EN
  localparam logic [SHAMT_W-1:0] ONE   = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] W_MOD = SHAMT_W'(WIDTH);

  logic               carry_bit;
  logic [SHAMT_W-1:0] lsl_idx;

  // Last bit out of this step: Rx[WIDTH-s] for LSL, Rx[s-1] for all right shifts.
  assign lsl_idx = W_MOD - step_amt;

  always_comb begin
    carry_bit = 1'b0;
    if (mode_q == M_LSL) carry_bit = Rx[lsl_idx];
    else                 carry_bit = Rx[step_amt - ONE];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (accept) begin
      carry <= 1'b0;
    end else if (state == S_SHIFT) begin
      carry <= carry_bit;
    end
  end
`endif

endmodule
